// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO: stores {lfd tag, byte}, tracks packet framing on the read side.
// Optional read-stall auto-flush is enabled by defining ROUTER_FIFO_TIMEOUT_EN.
module router_pkt_fifo #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AF_LEVEL    = 14,
    parameter int unsigned TIMEOUT_CYC = 30
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              soft_rst_i,
    input  logic              we_i,
    input  logic              lfd_state_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              re_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              len_err_o,
    output logic              timeout_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned CntW = DATA_W - 2;
    localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   rd_entry;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
    logic [CntW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d, sop_q, sop_d, eop_q, eop_d;
    logic              empty_q, empty_d, full_q, full_d, af_q, af_d, len_err_q, len_err_d;
    logic              tmo_fire, flush, do_wr, do_rd;

    assign flush = soft_rst_i | tmo_fire;
    assign do_wr = we_i & ~full_q & ~flush;
    assign do_rd = re_i & ~empty_q & ~flush;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state_i, din_i};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pkt_cnt_d    = pkt_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        len_err_d    = len_err_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pkt_cnt_d = '0;
            dout_d    = '0;
            len_err_d = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_d     = rd_ptr_q + PW'(1);
                dout_d       = rd_entry[DATA_W-1:0];
                dout_valid_d = 1'b1;
                if (rd_entry[DATA_W]) begin
                    // Header: expect length payload bytes plus one parity byte.
                    pkt_cnt_d = rd_entry[DATA_W-1:2] + CntW'(1);
                    sop_d     = 1'b1;
                    if (pkt_cnt_q != '0) begin
                        len_err_d = 1'b1;
                    end
                end else if (pkt_cnt_q == '0) begin
                    len_err_d = 1'b1;
                end else begin
                    pkt_cnt_d = pkt_cnt_q - CntW'(1);
                    eop_d     = (pkt_cnt_q == CntW'(1));
                end
            end
        end
        occ     = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        af_d    = (occ >= AfLevel);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            len_err_q    <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            af_q         <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            len_err_q    <= len_err_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            af_q         <= af_d;
        end
    end

`ifdef ROUTER_FIFO_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);
    logic [StallW-1:0] stall_q, stall_d;
    logic              stalled, timeout_q;

    assign stalled  = ~empty_q & ~re_i;
    assign tmo_fire = stalled && (stall_q == StallW'(TIMEOUT_CYC - 1));
    assign stall_d  = (flush || !stalled) ? '0 : stall_q + StallW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= tmo_fire;
        end
    end
    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign dout_o        = dout_q;
    assign dout_valid_o  = dout_valid_q;
    assign sop_o         = sop_q;
    assign eop_o         = eop_q;
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign almost_full_o = af_q;
    assign len_err_o     = len_err_q;

endmodule
